// File: rtl/fetch_unit_if.sv
// Bus bundle between the fetch stage, instruction memory, the execute redirect
// path and decode. The master modport is the fetch unit's view; the slave
// modport is the view of everything around it.
interface fetch_unit_if #(
  parameter int XLEN = 32,
  parameter int ILEN = 32
);
  logic            mem_req_valid;
  logic            mem_req_ready;
  logic [XLEN-1:0] mem_req_addr;
  logic            mem_resp_valid;
  logic [ILEN-1:0] mem_resp_data;
  logic            mem_resp_fault;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [ILEN-1:0] out_instr;
  logic            out_fault;

  modport master (
    output mem_req_valid, mem_req_addr,
    input  mem_req_ready,
    input  mem_resp_valid, mem_resp_data, mem_resp_fault,
    input  redirect_valid, redirect_pc,
    output out_valid, out_pc, out_instr, out_fault,
    input  out_ready
  );

  modport slave (
    input  mem_req_valid, mem_req_addr,
    output mem_req_ready,
    output mem_resp_valid, mem_resp_data, mem_resp_fault,
    output redirect_valid, redirect_pc,
    input  out_valid, out_pc, out_instr, out_fault,
    output out_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage. Issues word-aligned requests, buffers in-order
// responses in a small FIFO whose free space doubles as the request credit,
// and hands {pc, instr, fault} to decode. A redirect flushes the buffer and
// marks every request still in flight as stale so its response is dropped.
module fetch_unit #(
  parameter int              XLEN       = 32,
  parameter int              ILEN       = 32,
  parameter logic [XLEN-1:0] RESET_PC   = '0,
  parameter int              FIFO_DEPTH = 4
) (
  input logic         clock,
  input logic         reset,
  fetch_unit_if.master bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  // S_MISALIGN is the single cycle after a misaligned redirect in which the
  // synthetic fault entry is queued instead of fetching.
  typedef enum logic [1:0] {
    S_RUN      = 2'd0,
    S_MISALIGN = 2'd1,
    S_HALT     = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] fetch_pc_q, resp_pc_q;
  logic [CW-1:0]   outstanding_q, outstanding_d, drop_q, count_q;
  logic [AW-1:0]   rd_ptr_q, wr_ptr_q;
  logic [XLEN-1:0] fifo_pc    [FIFO_DEPTH];
  logic [ILEN-1:0] fifo_instr [FIFO_DEPTH];
  logic            fifo_fault [FIFO_DEPTH];

  logic            req_valid, req_fire, resp_drop, push, push_fault, pop, head_valid;
  logic [ILEN-1:0] push_instr;

  assign bus.mem_req_valid = !reset && req_valid;
  assign bus.mem_req_addr  = reset ? RESET_PC : fetch_pc_q;
  assign req_fire          = bus.mem_req_valid && bus.mem_req_ready;

  assign head_valid        = !reset && (count_q != '0);
  assign pop               = head_valid && bus.out_ready;
  assign bus.out_valid     = head_valid;
  assign bus.out_pc        = head_valid ? fifo_pc[rd_ptr_q]    : '0;
  assign bus.out_instr     = head_valid ? fifo_instr[rd_ptr_q] : '0;
  assign bus.out_fault     = head_valid && fifo_fault[rd_ptr_q];

  assign outstanding_d     = outstanding_q + CW'(req_fire) - CW'(bus.mem_resp_valid);

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state_q <= S_RUN;
    else       state_q <= state_d;
  end

  // Next state: a kept fault response halts fetch; a redirect always wins.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RUN:      if (bus.mem_resp_valid && (drop_q == '0) && bus.mem_resp_fault) state_d = S_HALT;
      S_MISALIGN: state_d = S_HALT;
      default:    state_d = S_HALT;
    endcase
    if (bus.redirect_valid)
      state_d = (bus.redirect_pc[1:0] != 2'b00) ? S_MISALIGN : S_RUN;
  end

  // State outputs: request credit, and what (if anything) gets pushed this cycle.
  always_comb begin
    req_valid  = 1'b0;
    push       = 1'b0;
    push_fault = 1'b0;
    push_instr = '0;
    resp_drop  = bus.mem_resp_valid && (drop_q != '0);
    case (state_q)
      S_RUN: begin
        req_valid = ({1'b0, outstanding_q} + {1'b0, count_q}) < (CW + 1)'(FIFO_DEPTH);
        if (bus.mem_resp_valid && !resp_drop) begin
          push       = 1'b1;
          push_fault = bus.mem_resp_fault;
          push_instr = bus.mem_resp_fault ? '0 : bus.mem_resp_data;
        end
      end
      S_MISALIGN: begin
        push       = 1'b1;
        push_fault = 1'b1;
      end
      default: ;
    endcase
  end

  // PC tracking plus in-flight and stale-response counters.
  always_ff @(posedge clock) begin
    if (reset) begin
      fetch_pc_q    <= RESET_PC;
      resp_pc_q     <= RESET_PC;
      outstanding_q <= '0;
      drop_q        <= '0;
    end else begin
      outstanding_q <= outstanding_d;
      if (bus.redirect_valid) begin
        fetch_pc_q <= bus.redirect_pc;
        resp_pc_q  <= bus.redirect_pc;
        drop_q     <= outstanding_d;
      end else begin
        if (req_fire)  fetch_pc_q <= fetch_pc_q + XLEN'(4);
        if (push)      resp_pc_q  <= resp_pc_q + XLEN'(4);
        if (resp_drop) drop_q     <= drop_q - CW'(1);
      end
    end
  end

  // FIFO occupancy and pointers; a redirect discards everything, including this cycle's push/pop.
  always_ff @(posedge clock) begin
    if (reset || bus.redirect_valid) begin
      count_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + CW'(push) - CW'(pop);
    end
  end

  // FIFO storage; entries are only ever read while the head is valid.
  always_ff @(posedge clock) begin
    if (push) begin
      fifo_pc[wr_ptr_q]    <= resp_pc_q;
      fifo_instr[wr_ptr_q] <= push_instr;
      fifo_fault[wr_ptr_q] <= push_fault;
    end
  end
endmodule
